// File: rtl/ipif_bus_initiator.sv
// ipif_bus_initiator: command/response front end that drives IPIF-style
// Bus2IP_* strobes toward a slave register block and waits for its ack.
// Optional watchdog on ACCESS enabled by defining IPIF_INIT_TIMEOUT_EN.
module ipif_bus_initiator #(
    parameter int unsigned C_NUM_CS   = 2,
    parameter int unsigned C_CS_IDX_W = 1,
    parameter int unsigned C_TIMEOUT  = 64
) (
    input  logic                  Bus2IP_Clk,
    input  logic                  Bus2IP_Resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rnw,
    input  logic [C_CS_IDX_W-1:0] cmd_cs,
    input  logic [0:31]           cmd_addr,
    input  logic [0:31]           cmd_data,
    input  logic [0:3]            cmd_be,
    output logic                  rsp_valid,
    output logic [0:31]           rsp_data,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic [0:31]           Bus2IP_Addr,
    output logic [0:C_NUM_CS-1]   Bus2IP_CS,
    output logic                  Bus2IP_RNW,
    output logic [0:31]           Bus2IP_Data,
    output logic [0:3]            Bus2IP_BE,
    input  logic [0:31]           IP2Bus_Data,
    input  logic                  IP2Bus_RdAck,
    input  logic                  IP2Bus_WrAck,
    input  logic                  IP2Bus_Error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [0:31]         rsp_data_q, rsp_data_d;
    logic                rsp_error_q, rsp_error_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [0:31]         addr_q, addr_d;
    logic [0:C_NUM_CS-1] cs_q, cs_d;
    logic                rnw_q, rnw_d;
    logic [0:31]         wdata_q, wdata_d;
    logic [0:3]          be_q, be_d;

    logic [0:C_NUM_CS-1] cs_sel_c;
    logic                cs_valid_c;
    logic                ack_c;
    logic                tmo_expire_c;

    // Decode the requested chip-select index into a one-hot pattern.
    always_comb begin
        cs_sel_c = '0;
        for (int unsigned i = 0; i < C_NUM_CS; i++) begin
            cs_sel_c[i] = (32'(cmd_cs) == i);
        end
    end

    assign cs_valid_c = (32'(cmd_cs) < C_NUM_CS);

    // Only the ack matching the current direction completes the access.
    assign ack_c = rnw_q ? IP2Bus_RdAck : IP2Bus_WrAck;

`ifdef IPIF_INIT_TIMEOUT_EN
    localparam int unsigned TMO_W = 16;

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Count ACCESS cycles; cleared on entry and whenever ACCESS is left.
    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q == ACCESS) && (state_d == ACCESS)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign tmo_expire_c = (state_q == ACCESS) && (tmo_cnt_q == TMO_W'(C_TIMEOUT - 1));
`else
    assign tmo_expire_c = 1'b0;
`endif

    // Next-state and next-output logic; all outputs are registered from here.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        addr_d        = addr_q;
        cs_d          = cs_q;
        rnw_d         = rnw_q;
        wdata_d       = wdata_q;
        be_d          = be_q;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cs_valid_c) begin
                        state_d = ACCESS;
                        addr_d  = cmd_addr;
                        cs_d    = cs_sel_c;
                        rnw_d   = cmd_rnw;
                        wdata_d = cmd_data;
                        be_d    = cmd_be;
                    end else begin
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_data_d    = '0;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (ack_c || tmo_expire_c) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    addr_d      = '0;
                    cs_d        = '0;
                    rnw_d       = 1'b0;
                    wdata_d     = '0;
                    be_d        = '0;
                    if (ack_c) begin
                        rsp_data_d    = (rnw_q && !IP2Bus_Error) ? IP2Bus_Data : '0;
                        rsp_error_d   = IP2Bus_Error;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        rsp_data_d    = '0;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            addr_q        <= '0;
            cs_q          <= '0;
            rnw_q         <= 1'b0;
            wdata_q       <= '0;
            be_q          <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            addr_q        <= addr_d;
            cs_q          <= cs_d;
            rnw_q         <= rnw_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign Bus2IP_Addr = addr_q;
    assign Bus2IP_CS   = cs_q;
    assign Bus2IP_RNW  = rnw_q;
    assign Bus2IP_Data = wdata_q;
    assign Bus2IP_BE   = be_q;

endmodule

// File: tb/tb_ipif_bus_initiator.sv
// Directed bench for ipif_bus_initiator: reset, write, read, error/stray ack,
// bad chip select, watchdog (or indefinite wait), reset mid-access, back-to-back.
module tb_ipif_bus_initiator;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rnw;
    logic [1:0]  cmd_cs;
    logic [0:31] cmd_addr;
    logic [0:31] cmd_data;
    logic [0:3]  cmd_be;
    logic        rsp_valid;
    logic [0:31] rsp_data;
    logic        rsp_error;
    logic        rsp_timeout;
    logic [0:31] b_addr;
    logic [0:1]  b_cs;
    logic        b_rnw;
    logic [0:31] b_data;
    logic [0:3]  b_be;
    logic [0:31] s_data;
    logic        s_rdack;
    logic        s_wrack;
    logic        s_err;

    int n_cmp;
    int n_err;

    ipif_bus_initiator #(
        .C_NUM_CS  (2),
        .C_CS_IDX_W(2),
        .C_TIMEOUT (8)
    ) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Resetn(rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rnw      (cmd_rnw),
        .cmd_cs       (cmd_cs),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_be       (cmd_be),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .rsp_timeout  (rsp_timeout),
        .Bus2IP_Addr  (b_addr),
        .Bus2IP_CS    (b_cs),
        .Bus2IP_RNW   (b_rnw),
        .Bus2IP_Data  (b_data),
        .Bus2IP_BE    (b_be),
        .IP2Bus_Data  (s_data),
        .IP2Bus_RdAck (s_rdack),
        .IP2Bus_WrAck (s_wrack),
        .IP2Bus_Error (s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rnw, input logic [1:0] cs,
                         input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_cs    = cs;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_be    = be;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_rnw   = 1'b0;
        cmd_cs    = '0;
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_be    = '0;
        s_data    = '0;
        s_rdack   = 1'b0;
        s_wrack   = 1'b0;
        s_err     = 1'b0;

        // Reset held for three cycles.
        tick(); tick(); tick();
        chk("rst_ready", 32'(cmd_ready), 32'h0);
        chk("rst_rspv",  32'(rsp_valid), 32'h0);
        chk("rst_cs",    32'(b_cs),      32'h0);
        chk("rst_addr",  32'(b_addr),    32'h0);
        chk("rst_data",  32'(rsp_data),  32'h0);
        chk("rst_err",   32'(rsp_error), 32'h0);
        rstn = 1'b1;
        tick();
        chk("rel_ready", 32'(cmd_ready), 32'h1);

        // Write to cs0, WrAck in the 4th ACCESS cycle.
        issue(1'b0, 2'd0, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
        tick();
        cmd_valid = 1'b0;
        chk("wr_ready", 32'(cmd_ready), 32'h0);
        chk("wr_rnw",   32'(b_rnw),     32'h0);
        chk("wr_be",    32'(b_be),      32'hF);
        chk("wr_addr",  32'(b_addr),    32'h4);
        for (int k = 1; k <= 4; k++) begin
            chk("wr_cs",   32'(b_cs),      32'h2);
            chk("wr_bdat", 32'(b_data),    32'hDEAD_BEEF);
            chk("wr_rspv", 32'(rsp_valid), 32'h0);
            if (k == 4) begin
                s_wrack = 1'b1;
                s_data  = 32'hAAAA_AAAA;
            end
            tick();
        end
        s_wrack = 1'b0;
        s_data  = '0;
        chk("wr_rsp_v",   32'(rsp_valid), 32'h1);
        chk("wr_rsp_e",   32'(rsp_error), 32'h0);
        chk("wr_rsp_d",   32'(rsp_data),  32'h0);
        chk("wr_rsp_cs",  32'(b_cs),      32'h0);
        chk("wr_rsp_rdy", 32'(cmd_ready), 32'h0);
        tick();
        chk("wr_idle_v",   32'(rsp_valid), 32'h0);
        chk("wr_idle_rdy", 32'(cmd_ready), 32'h1);

        // Read from cs1, single-cycle slave.
        issue(1'b1, 2'd1, 32'h0000_0010, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        chk("rd_cs",  32'(b_cs),  32'h1);
        chk("rd_rnw", 32'(b_rnw), 32'h1);
        s_rdack = 1'b1;
        s_data  = 32'h1234_5678;
        tick();
        s_rdack = 1'b0;
        s_data  = '0;
        chk("rd_rsp_v",  32'(rsp_valid), 32'h1);
        chk("rd_rsp_d",  32'(rsp_data),  32'h1234_5678);
        chk("rd_rsp_e",  32'(rsp_error), 32'h0);
        chk("rd_rsp_cs", 32'(b_cs),      32'h0);
        tick();
        chk("rd_idle_v", 32'(rsp_valid), 32'h0);
        chk("rd_hold_d", 32'(rsp_data),  32'h1234_5678);

        // Stray acks in IDLE are ignored.
        s_rdack = 1'b1;
        s_wrack = 1'b1;
        tick();
        s_rdack = 1'b0;
        s_wrack = 1'b0;
        chk("idle_ack_v",   32'(rsp_valid), 32'h0);
        chk("idle_ack_rdy", 32'(cmd_ready), 32'h1);
        chk("idle_ack_cs",  32'(b_cs),      32'h0);

        // Read on cs0: stray WrAck ignored, then RdAck with error.
        issue(1'b1, 2'd0, 32'h0000_0020, 32'h0, 4'h3);
        tick();
        cmd_valid = 1'b0;
        s_wrack   = 1'b1;
        tick();
        s_wrack = 1'b0;
        chk("stray_cs",   32'(b_cs),      32'h2);
        chk("stray_rspv", 32'(rsp_valid), 32'h0);
        s_rdack = 1'b1;
        s_err   = 1'b1;
        tick();
        s_rdack = 1'b0;
        s_err   = 1'b0;
        chk("err_rsp_v", 32'(rsp_valid), 32'h1);
        chk("err_rsp_e", 32'(rsp_error), 32'h1);
        chk("err_rsp_t", 32'(rsp_timeout), 32'h0);
        tick();

        // Bad chip-select index: no bus activity, error one cycle later.
        issue(1'b0, 2'd2, 32'h0000_0030, 32'h1111_1111, 4'hF);
        tick();
        cmd_valid = 1'b0;
        chk("badcs_v",  32'(rsp_valid), 32'h1);
        chk("badcs_e",  32'(rsp_error), 32'h1);
        chk("badcs_d",  32'(rsp_data),  32'h0);
        chk("badcs_cs", 32'(b_cs),      32'h0);
        tick();
        chk("badcs_idle_v", 32'(rsp_valid), 32'h0);

`ifdef IPIF_INIT_TIMEOUT_EN
        // No ack: CS high exactly 8 cycles, then timeout response.
        issue(1'b1, 2'd1, 32'h0000_0040, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("tmo_cs",   32'(b_cs),      32'h1);
            chk("tmo_rspv", 32'(rsp_valid), 32'h0);
            tick();
        end
        chk("tmo_v",  32'(rsp_valid),   32'h1);
        chk("tmo_e",  32'(rsp_error),   32'h1);
        chk("tmo_t",  32'(rsp_timeout), 32'h1);
        chk("tmo_d",  32'(rsp_data),    32'h0);
        chk("tmo_cs0", 32'(b_cs),       32'h0);
        tick();

        // Ack on the 8th cycle wins over expiry.
        issue(1'b1, 2'd0, 32'h0000_0044, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("tmo8_cs", 32'(b_cs), 32'h2);
            if (k == 8) begin
                s_rdack = 1'b1;
                s_data  = 32'h5A5A_5A5A;
            end
            tick();
        end
        s_rdack = 1'b0;
        s_data  = '0;
        chk("tmo8_v", 32'(rsp_valid),   32'h1);
        chk("tmo8_e", 32'(rsp_error),   32'h0);
        chk("tmo8_t", 32'(rsp_timeout), 32'h0);
        chk("tmo8_d", 32'(rsp_data),    32'h5A5A_5A5A);
        tick();
`else
        // Without the watchdog a silent slave is waited on indefinitely.
        issue(1'b1, 2'd1, 32'h0000_0040, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            chk("wait_cs",   32'(b_cs),      32'h1);
            chk("wait_rspv", 32'(rsp_valid), 32'h0);
            if (k == 20) begin
                s_rdack = 1'b1;
                s_data  = 32'h5A5A_5A5A;
            end
            tick();
        end
        s_rdack = 1'b0;
        s_data  = '0;
        chk("wait_v", 32'(rsp_valid),   32'h1);
        chk("wait_e", 32'(rsp_error),   32'h0);
        chk("wait_t", 32'(rsp_timeout), 32'h0);
        chk("wait_d", 32'(rsp_data),    32'h5A5A_5A5A);
        tick();
`endif

        // Reset asserted in ACCESS cycle 2.
        issue(1'b0, 2'd1, 32'h0000_0050, 32'h2222_2222, 4'hF);
        tick();
        cmd_valid = 1'b0;
        chk("rsta_cs1", 32'(b_cs), 32'h1);
        tick();
        chk("rsta_cs2", 32'(b_cs), 32'h1);
        rstn = 1'b0;
        tick();
        chk("rsta_cs",   32'(b_cs),      32'h0);
        chk("rsta_rspv", 32'(rsp_valid), 32'h0);
        chk("rsta_rdy",  32'(cmd_ready), 32'h0);
        rstn = 1'b1;
        tick();
        chk("rsta_rspv2", 32'(rsp_valid), 32'h0);
        chk("rsta_rdy2",  32'(cmd_ready), 32'h1);

        // Back-to-back commands: CS low for RESP + IDLE between them.
        issue(1'b0, 2'd0, 32'h0000_0060, 32'h3333_3333, 4'hF);
        tick();
        issue(1'b0, 2'd1, 32'h0000_0064, 32'h4444_4444, 4'hC);
        chk("b2b_a_cs", 32'(b_cs), 32'h2);
        s_wrack = 1'b1;
        tick();
        s_wrack = 1'b0;
        chk("b2b_a_rspv", 32'(rsp_valid), 32'h1);
        chk("b2b_gap1",   32'(b_cs),      32'h0);
        tick();
        chk("b2b_gap2",  32'(b_cs),      32'h0);
        chk("b2b_rdy",   32'(cmd_ready), 32'h1);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_b_cs",   32'(b_cs),   32'h1);
        chk("b2b_b_addr", 32'(b_addr), 32'h64);
        chk("b2b_b_be",   32'(b_be),   32'hC);
        s_wrack = 1'b1;
        tick();
        s_wrack = 1'b0;
        chk("b2b_b_rspv", 32'(rsp_valid), 32'h1);
        chk("b2b_b_e",    32'(rsp_error), 32'h0);
        tick();
        chk("b2b_end_v", 32'(rsp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
